// File: rtl/digit_entry_buffer.sv
// digit_entry_buffer: ordered store of keypad code digits with
// backspace, soft clear and optional inactivity auto-clear.
//
// Ports:
//   clk            rising-edge clock
//   reset_switch_n synchronous active-low reset
//   clear          soft clear strobe
//   key_valid      key strobe, key_value qualified by it
//   key_value      digit from the keypad decoder
//   backspace      remove-last-digit strobe
//   digits         slot i at [i*DIGIT_W +: DIGIT_W], slot 0 oldest
//   count          digits currently held
//   full           count == NUM_DIGITS
//   entry_done     pulse when the last slot is filled
//   key_rejected   pulse when a key strobe was dropped
//   timeout        pulse when the idle auto-clear fired
module digit_entry_buffer #(
  parameter int NUM_DIGITS     = 6,
  parameter int DIGIT_W        = 4,
  parameter int MAX_KEY        = 9,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                            clk,
  input  logic                            reset_switch_n,
  input  logic                            clear,
  input  logic                            key_valid,
  input  logic [DIGIT_W-1:0]              key_value,
  input  logic                            backspace,
  output logic [NUM_DIGITS*DIGIT_W-1:0]   digits,
  output logic [$clog2(NUM_DIGITS+1)-1:0] count,
  output logic                            full,
  output logic                            entry_done,
  output logic                            key_rejected,
  output logic                            timeout
);

  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int IW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int EXP_AT =
    (TIMEOUT_CYCLES > 2) ? TIMEOUT_CYCLES - 2 : 0;

  localparam logic [CW-1:0] CNT_MAX  = CW'(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] IDLE_EXP = IW'(EXP_AT);
  localparam logic [IW-1:0] IDLE_ONE = IW'(1);
  localparam logic [31:0]   KEY_MAX  = 32'(MAX_KEY);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_FULL
  } state_t;

  logic [DIGIT_W-1:0] r_slot [NUM_DIGITS];
  logic [CW-1:0]      r_count;
  logic [IW-1:0]      r_idle;
  logic               r_full;
  logic               r_done;
  logic               r_rej;
  logic               r_to;

  state_t             w_state;
  logic [31:0]        w_key_ext;
  logic               w_key_ok;
  logic               w_strobe;
  logic               w_expire;
  logic               w_do_clr;
  logic               w_do_to;
  logic               w_do_bs;
  logic               w_do_add;
  logic               w_do_rej;
  logic [IW-1:0]      w_idle_nxt;

  always_comb begin
    w_state = ST_ENTRY;
    unique case (1'b1)
      (r_count == '0):      w_state = ST_IDLE;
      (r_count == CNT_MAX): w_state = ST_FULL;
      default:              w_state = ST_ENTRY;
    endcase
  end

  assign w_key_ext = 32'(key_value);
  assign w_key_ok  = (w_key_ext <= KEY_MAX);
  assign w_strobe  = key_valid | backspace;

  // The idle counter holds EXP_AT during the quiet cycle whose
  // increment would land on TIMEOUT_CYCLES-1; that cycle wipes
  // the buffer, whatever strobes arrive alongside it.
  assign w_expire = (TIMEOUT_CYCLES > 0)
                  && (w_state != ST_IDLE)
                  && (r_idle == IDLE_EXP);

  // One-hot action select, highest priority first.
  assign w_do_clr = clear;
  assign w_do_to  = !clear && w_expire;
  assign w_do_bs  = !clear && !w_expire
                  && backspace
                  && (w_state != ST_IDLE);
  assign w_do_add = !clear && !w_expire
                  && !backspace
                  && key_valid
                  && w_key_ok
                  && (w_state != ST_FULL);

  // A key is dropped whenever it was not stored, unless a clear or
  // expiry swallowed the whole cycle.
  assign w_do_rej = !clear && !w_expire
                  && key_valid
                  && !w_do_add;

  always_comb begin
    w_idle_nxt = '0;
    if (TIMEOUT_CYCLES > 0) begin
      if (w_do_clr || w_do_to) begin
        w_idle_nxt = '0;
      end else if (w_state == ST_IDLE || w_strobe) begin
        w_idle_nxt = '0;
      end else begin
        w_idle_nxt = r_idle + IDLE_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_switch_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_slot[i] <= '0;
      end
      r_count <= '0;
      r_idle  <= '0;
      r_full  <= 1'b0;
      r_done  <= 1'b0;
      r_rej   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_done <= w_do_add && (r_count == CNT_LAST);
      r_rej  <= w_do_rej;
      r_to   <= w_do_to;
      r_idle <= w_idle_nxt;
      unique case (1'b1)
        w_do_clr, w_do_to: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            r_slot[i] <= '0;
          end
          r_count <= '0;
          r_full  <= 1'b0;
        end
        w_do_bs: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i == int'(r_count) - 1) begin
              r_slot[i] <= '0;
            end
          end
          r_count <= r_count - CNT_ONE;
          r_full  <= 1'b0;
        end
        w_do_add: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i == int'(r_count)) begin
              r_slot[i] <= key_value;
            end
          end
          r_count <= r_count + CNT_ONE;
          r_full  <= (r_count == CNT_LAST);
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    digits = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digits[i*DIGIT_W +: DIGIT_W] = r_slot[i];
    end
  end

  assign count        = r_count;
  assign full         = r_full;
  assign entry_done   = r_done;
  assign key_rejected = r_rej;
  assign timeout      = r_to;

endmodule

// File: tb/tb_digit_entry_buffer.sv
// Bench for digit_entry_buffer: two configurations checked against a
// digit-list model every cycle plus directed literal expectations.
module tb_digit_entry_buffer;

  localparam int NA = 6;
  localparam int WA = 4;
  localparam int MA = 9;
  localparam int TA = 8;
  localparam int NB = 4;
  localparam int WB = 8;
  localparam int MB = 200;
  localparam int TB = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;

  logic              a_clr, a_kv, a_bs;
  logic [WA-1:0]     a_kval;
  logic [NA*WA-1:0]  a_dig;
  logic [2:0]        a_cnt;
  logic              a_full, a_done, a_rej, a_to;

  logic              b_clr, b_kv, b_bs;
  logic [WB-1:0]     b_kval;
  logic [NB*WB-1:0]  b_dig;
  logic [2:0]        b_cnt;
  logic              b_full, b_done, b_rej, b_to;

  digit_entry_buffer #(
    .NUM_DIGITS(NA), .DIGIT_W(WA),
    .MAX_KEY(MA), .TIMEOUT_CYCLES(TA)
  ) dut_a (
    .clk(clk), .reset_switch_n(rstn),
    .clear(a_clr), .key_valid(a_kv),
    .key_value(a_kval), .backspace(a_bs),
    .digits(a_dig), .count(a_cnt), .full(a_full),
    .entry_done(a_done), .key_rejected(a_rej),
    .timeout(a_to)
  );

  digit_entry_buffer #(
    .NUM_DIGITS(NB), .DIGIT_W(WB),
    .MAX_KEY(MB), .TIMEOUT_CYCLES(TB)
  ) dut_b (
    .clk(clk), .reset_switch_n(rstn),
    .clear(b_clr), .key_valid(b_kv),
    .key_value(b_kval), .backspace(b_bs),
    .digits(b_dig), .count(b_cnt), .full(b_full),
    .entry_done(b_done), .key_rejected(b_rej),
    .timeout(b_to)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_on = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: each unit is a list of entered digits plus the number of
  // cycles since the last activity (the activity cycle counts as 1).
  // The list is wiped in the TIMEOUT_CYCLES-th cycle from activity.
  int   m_slot [2][8];
  int   m_size [2] = '{0, 0};
  int   m_age  [2] = '{1, 1};
  logic m_done [2] = '{1'b0, 1'b0};
  logic m_rej  [2] = '{1'b0, 1'b0};
  logic m_to   [2] = '{1'b0, 1'b0};

  task automatic wipe(input int u);
    for (int i = 0; i < 8; i++) m_slot[u][i] = 0;
    m_size[u] = 0;
    m_age[u]  = 1;
  endtask

  task automatic model_step(input int u, input logic clr,
                            input logic kv, input int kval,
                            input logic bs);
    int n, mx, t;
    logic was_empty;
    n  = (u == 0) ? NA : NB;
    mx = (u == 0) ? MA : MB;
    t  = (u == 0) ? TA : TB;
    m_done[u] = 1'b0;
    m_rej[u]  = 1'b0;
    m_to[u]   = 1'b0;
    if (!rstn || clr) begin
      wipe(u);
    end else if (t > 0 && m_size[u] > 0 && m_age[u] >= t - 1) begin
      wipe(u);
      m_to[u] = 1'b1;
    end else begin
      was_empty = (m_size[u] == 0);
      if (bs) begin
        if (m_size[u] > 0) begin
          m_size[u]--;
          m_slot[u][m_size[u]] = 0;
        end
        if (kv) m_rej[u] = 1'b1;
      end else if (kv) begin
        if (kval <= mx && m_size[u] < n) begin
          m_slot[u][m_size[u]] = kval;
          m_size[u]++;
          if (m_size[u] == n) m_done[u] = 1'b1;
        end else begin
          m_rej[u] = 1'b1;
        end
      end
      m_age[u] = (was_empty || kv || bs) ? 1 : m_age[u] + 1;
    end
  endtask

  function automatic logic [63:0] exp_dig(input int u);
    logic [63:0] r;
    int n, w;
    n = (u == 0) ? NA : NB;
    w = (u == 0) ? WA : WB;
    r = '0;
    for (int i = 0; i < n; i++) r |= 64'(m_slot[u][i]) << (i * w);
    return r;
  endfunction

  always @(posedge clk) begin
    model_step(0, a_clr, a_kv, int'(a_kval), a_bs);
    model_step(1, b_clr, b_kv, int'(b_kval), b_bs);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("A.digits", 64'(a_dig), exp_dig(0));
      chk("A.count", 64'(a_cnt), 64'(m_size[0]));
      chk("A.full", 64'(a_full), 64'(m_size[0] == NA));
      chk("A.entry_done", 64'(a_done), 64'(m_done[0]));
      chk("A.key_rejected", 64'(a_rej), 64'(m_rej[0]));
      chk("A.timeout", 64'(a_to), 64'(m_to[0]));
      chk("B.digits", 64'(b_dig), exp_dig(1));
      chk("B.count", 64'(b_cnt), 64'(m_size[1]));
      chk("B.full", 64'(b_full), 64'(m_size[1] == NB));
      chk("B.entry_done", 64'(b_done), 64'(m_done[1]));
      chk("B.key_rejected", 64'(b_rej), 64'(m_rej[1]));
      chk("B.timeout", 64'(b_to), 64'(m_to[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a(input int n);
    repeat (n) tick();
  endtask

  task automatic key_a(input int v);
    a_kv = 1'b1;
    a_kval = WA'(v);
    tick();
    a_kv = 1'b0;
  endtask

  task automatic key_b(input int v);
    b_kv = 1'b1;
    b_kval = WB'(v);
    tick();
    b_kv = 1'b0;
  endtask

  task automatic bs_a();
    a_bs = 1'b1;
    tick();
    a_bs = 1'b0;
  endtask

  task automatic clr_a();
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    a_clr = 1'b0; a_kv = 1'b0; a_bs = 1'b0; a_kval = '0;
    b_clr = 1'b0; b_kv = 1'b0; b_bs = 1'b0; b_kval = '0;
    tick();
    tick();
    chk_on = 1'b1;
    chk("rst.count", 64'(a_cnt), 64'd0);
    chk("rst.digits", 64'(a_dig), 64'd0);
    rstn = 1'b1;

    // reset mid-entry, with a key strobe that must be ignored
    key_a(1); key_a(2); key_a(3);
    chk("t1.count3", 64'(a_cnt), 64'd3);
    chk("t1.digits", 64'(a_dig), 64'h321);
    rstn = 1'b0; a_kv = 1'b1; a_kval = 4'd5;
    tick();
    rstn = 1'b1; a_kv = 1'b0;
    chk("t1.rst_count", 64'(a_cnt), 64'd0);
    chk("t1.rst_digits", 64'(a_dig), 64'd0);
    chk("t1.rst_rej", 64'(a_rej), 64'd0);

    // fill all six slots, then overflow
    for (int k = 1; k <= 5; k++) begin
      key_a(k);
      chk("t2.done_early", 64'(a_done), 64'd0);
    end
    key_a(6);
    chk("t2.digits", 64'(a_dig), 64'h654321);
    chk("t2.full", 64'(a_full), 64'd1);
    chk("t2.done", 64'(a_done), 64'd1);
    key_a(7);
    chk("t2.rej7", 64'(a_rej), 64'd1);
    chk("t2.done_once", 64'(a_done), 64'd0);
    chk("t2.digits_kept", 64'(a_dig), 64'h654321);
    clr_a();
    chk("t2.clr_count", 64'(a_cnt), 64'd0);

    // edit with backspace
    key_a(4); key_a(2); bs_a(); key_a(9);
    chk("t3.count", 64'(a_cnt), 64'd2);
    chk("t3.digits", 64'(a_dig), 64'h94);
    clr_a();

    // out-of-range key, idle backspace, key+backspace together
    key_a(10);
    chk("t4.rejA", 64'(a_rej), 64'd1);
    chk("t4.countA", 64'(a_cnt), 64'd0);
    bs_a();
    chk("t4.bs_idle_rej", 64'(a_rej), 64'd0);
    chk("t4.bs_idle_cnt", 64'(a_cnt), 64'd0);
    key_a(1); key_a(2);
    a_kv = 1'b1; a_kval = 4'd5; a_bs = 1'b1;
    tick();
    a_kv = 1'b0; a_bs = 1'b0;
    chk("t4.kb_count", 64'(a_cnt), 64'd1);
    chk("t4.kb_rej", 64'(a_rej), 64'd1);
    chk("t4.kb_digits", 64'(a_dig), 64'h1);
    clr_a();

    // timeout: key then seven quiet cycles, the last one wipes
    key_a(3);
    idle_a(6);
    chk("t5.hold_count", 64'(a_cnt), 64'd1);
    chk("t5.hold_to", 64'(a_to), 64'd0);
    tick();
    chk("t5.to", 64'(a_to), 64'd1);
    chk("t5.to_count", 64'(a_cnt), 64'd0);
    chk("t5.to_digits", 64'(a_dig), 64'd0);
    tick();
    chk("t5.to_pulse", 64'(a_to), 64'd0);
    key_a(3);
    idle_a(5);
    key_a(4);
    idle_a(6);
    chk("t5.restart_cnt", 64'(a_cnt), 64'd2);
    chk("t5.restart_to", 64'(a_to), 64'd0);
    tick();
    chk("t5.restart_fire", 64'(a_to), 64'd1);
    key_a(3);
    idle_a(6);
    key_a(5);
    chk("t5.race_to", 64'(a_to), 64'd1);
    chk("t5.race_rej", 64'(a_rej), 64'd0);
    chk("t5.race_cnt", 64'(a_cnt), 64'd0);

    // clear beats a simultaneous key
    key_a(1); key_a(2); key_a(3); key_a(4);
    a_clr = 1'b1; a_kv = 1'b1; a_kval = 4'd5;
    tick();
    a_clr = 1'b0; a_kv = 1'b0;
    chk("t6.clr_cnt", 64'(a_cnt), 64'd0);
    chk("t6.clr_dig", 64'(a_dig), 64'd0);
    chk("t6.clr_rej", 64'(a_rej), 64'd0);

    // wide configuration: 200 accepted, 201 rejected
    key_b(200);
    chk("t6b.cnt1", 64'(b_cnt), 64'd1);
    chk("t6b.dig1", 64'(b_dig), 64'hC8);
    key_b(201);
    chk("t6b.rej", 64'(b_rej), 64'd1);
    chk("t6b.cnt_kept", 64'(b_cnt), 64'd1);
    key_b(7); key_b(8); key_b(9);
    chk("t6b.full", 64'(b_full), 64'd1);
    chk("t6b.done", 64'(b_done), 64'd1);
    chk("t6b.digits", 64'(b_dig), 64'h090807C8);
    b_clr = 1'b1; b_kv = 1'b1; b_kval = 8'd3;
    tick();
    b_clr = 1'b0; b_kv = 1'b0;
    chk("t6b.clr_cnt", 64'(b_cnt), 64'd0);
    chk("t6b.clr_dig", 64'(b_dig), 64'd0);
    chk("t6b.clr_rej", 64'(b_rej), 64'd0);

    idle_a(3);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
